// File: rtl/nco_sweep_ctrl.sv
// Divider sequencer for the sine NCO: fixed, sawtooth and triangle sweeps between two
// divider values, with every divider change aligned to an NCO wrap for phase continuity.
module nco_sweep_ctrl #(
  parameter int DIV_W     = 16,
  parameter int DWELL_W   = 16,
  parameter int RESET_DIV = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [1:0]         cfg_mode,
  input  logic [DIV_W-1:0]   cfg_div_start,
  input  logic [DIV_W-1:0]   cfg_div_end,
  input  logic [DIV_W-1:0]   cfg_div_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               nco_sync,
  output logic [DIV_W-1:0]   nco_div,
  output logic               busy,
  output logic               step_stb,
  output logic               done
);

  localparam logic [1:0] MODE_HOLD     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_REPEAT   = 2'd2;
  localparam logic [1:0] MODE_TRIANGLE = 2'd3;
  localparam logic [DIV_W-1:0] RESET_DIV_V = DIV_W'(RESET_DIV);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_DWELL, S_LAST} state_t;

  state_t             state, state_nxt;
  logic [1:0]         mode_r;
  logic [DIV_W-1:0]   start_r, end_r, step_r;
  logic [DWELL_W-1:0] reload_r;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
  logic [DIV_W-1:0]   div_nxt, tgt, tgt_rev, step_val, rev_val;
  logic               nco_sync_q, sync_evt;
  logic               to_end, to_end_nxt;
  logic               stb_nxt, done_nxt, accept;
  logic               hold, up_fwd, up;

  // Move cur by step toward bound; overshoot or wrap past either end of the range clamps to bound.
  function automatic logic [DIV_W-1:0] step_toward(input logic [DIV_W-1:0] cur,
                                                   input logic [DIV_W-1:0] step,
                                                   input logic [DIV_W-1:0] bound,
                                                   input logic             dir_up);
    logic [DIV_W:0] ext;
    if (dir_up) begin
      ext = {1'b0, cur} + {1'b0, step};
      step_toward = (ext >= {1'b0, bound}) ? bound : ext[DIV_W-1:0];
    end else begin
      ext = {1'b0, cur} - {1'b0, step};
      step_toward = (ext[DIV_W] || (ext <= {1'b0, bound})) ? bound : ext[DIV_W-1:0];
    end
  endfunction

  assign sync_evt = nco_sync & ~nco_sync_q;
  assign hold     = (mode_r == MODE_HOLD) || (step_r == '0) || (start_r == end_r);
  assign up_fwd   = end_r > start_r;
  assign up       = to_end ? up_fwd : ~up_fwd;
  assign tgt      = to_end ? end_r : start_r;
  assign tgt_rev  = to_end ? start_r : end_r;
  assign step_val = step_toward(nco_div, step_r, tgt, up);
  assign rev_val  = step_toward(nco_div, step_r, tgt_rev, ~up);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      nco_sync_q <= 1'b0;
      nco_div    <= RESET_DIV_V;
      step_stb   <= 1'b0;
      done       <= 1'b0;
      to_end     <= 1'b1;
    end else begin
      state      <= state_nxt;
      nco_sync_q <= nco_sync;
      nco_div    <= div_nxt;
      step_stb   <= stb_nxt;
      done       <= done_nxt;
      to_end     <= to_end_nxt;
    end
  end

  // Sweep configuration is captured only when a start is accepted.
  always_ff @(posedge clk) begin
    dwell_cnt <= dwell_cnt_nxt;
    if (accept) begin
      mode_r   <= cfg_mode;
      start_r  <= cfg_div_start;
      end_r    <= cfg_div_end;
      step_r   <= cfg_div_step;
      reload_r <= (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    div_nxt       = nco_div;
    dwell_cnt_nxt = dwell_cnt;
    to_end_nxt    = to_end;
    stb_nxt       = 1'b0;
    done_nxt      = 1'b0;
    accept        = 1'b0;
    if (cfg_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            accept    = 1'b1;
            state_nxt = S_ARM;
          end
        end
        S_ARM: begin
          if (sync_evt) begin
            div_nxt       = start_r;
            stb_nxt       = 1'b1;
            dwell_cnt_nxt = reload_r;
            to_end_nxt    = 1'b1;
            state_nxt     = S_DWELL;
          end
        end
        S_DWELL: begin
          if (sync_evt && !hold) begin
            if (dwell_cnt != '0) begin
              dwell_cnt_nxt = dwell_cnt - DWELL_W'(1);
            end else begin
              div_nxt       = step_val;
              stb_nxt       = 1'b1;
              dwell_cnt_nxt = reload_r;
              if (step_val == tgt) state_nxt = S_LAST;
            end
          end
        end
        S_LAST: begin
          if (sync_evt) begin
            if (dwell_cnt != '0) begin
              dwell_cnt_nxt = dwell_cnt - DWELL_W'(1);
            end else begin
              case (mode_r)
                MODE_REPEAT: begin
                  div_nxt       = start_r;
                  stb_nxt       = 1'b1;
                  dwell_cnt_nxt = reload_r;
                  state_nxt     = S_DWELL;
                end
                // Leave the bound immediately so it is not visited twice in a row.
                MODE_TRIANGLE: begin
                  to_end_nxt    = ~to_end;
                  div_nxt       = rev_val;
                  stb_nxt       = 1'b1;
                  dwell_cnt_nxt = reload_r;
                  state_nxt     = (rev_val == tgt_rev) ? S_LAST : S_DWELL;
                end
                default: begin
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
                end
              endcase
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: sweeps are predicted from the list of divider points each
// mode visits, with every point held for max(dwell,1) NCO sync edges.
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_div_start = '0;
  logic [15:0] cfg_div_end = '0;
  logic [15:0] cfg_div_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic        nco_sync = 1'b0;
  logic [15:0] nco_div;
  logic        busy, step_stb, done;

  int checks = 0;
  int errors = 0;
  int stray  = 0;
  logic [15:0] obs_div;
  logic        obs_stb, obs_done, obs_busy;
  int walk_q[$];
  int pat_q[$];

  nco_sweep_ctrl #(.DIV_W(16), .DWELL_W(16), .RESET_DIV(8)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_mode(cfg_mode), .cfg_div_start(cfg_div_start), .cfg_div_end(cfg_div_end),
    .cfg_div_step(cfg_div_step), .cfg_dwell(cfg_dwell), .nco_sync(nco_sync),
    .nco_div(nco_div), .busy(busy), .step_stb(step_stb), .done(done)
  );

  always #5 clk = ~clk;

  // One NCO wrap: rising sync, outputs captured one clock later, then a random-length pulse.
  task automatic sync_edge();
    int hi, lo;
    hi = $urandom_range(0, 2);
    lo = $urandom_range(1, 3);
    @(negedge clk);
    nco_sync = 1'b1;
    @(negedge clk);
    obs_div = nco_div; obs_stb = step_stb; obs_done = done; obs_busy = busy;
    repeat (hi) begin @(negedge clk); if (step_stb || done) stray++; end
    nco_sync = 1'b0;
    repeat (lo) begin @(negedge clk); if (step_stb || done) stray++; end
  endtask

  task automatic scramble_cfg();
    cfg_mode = 2'($urandom); cfg_div_start = 16'($urandom); cfg_div_end = 16'($urandom);
    cfg_div_step = 16'($urandom); cfg_dwell = 16'($urandom_range(0, 3));
  endtask

  task automatic start_cfg(input logic [1:0] m, input int s, input int e, input int st, input int dw);
    @(negedge clk);
    cfg_mode = m; cfg_div_start = 16'(s); cfg_div_end = 16'(e);
    cfg_div_step = 16'(st); cfg_dwell = 16'(dw); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    scramble_cfg();
  endtask

  // Points visited from a to b in steps of st, the last one clamped onto b.
  task automatic walk(input int a, input int b, input int st);
    int v;
    walk_q.delete();
    v = a;
    walk_q.push_back(v);
    while (v != b) begin
      if (b > a) v = (v + st >= b) ? b : v + st;
      else       v = (v - st <= b) ? b : v - st;
      walk_q.push_back(v);
    end
  endtask

  task automatic run_sweep(input string name, input logic [1:0] m, input int s, input int e,
                           input int st, input int dw, input int nedges_in, input bit poke);
    int d, plen, idx, exp_div, nedges;
    bit hold, exp_stb, exp_done, exp_busy;
    d = (dw == 0) ? 1 : dw;
    hold = (m == 2'd0) || (st == 0) || (s == e);
    pat_q.delete();
    if (!hold) begin
      walk(s, e, st);
      pat_q = walk_q;
      if (m == 2'd3) begin
        walk(e, s, st);
        for (int i = 1; i < walk_q.size() - 1; i++) pat_q.push_back(walk_q[i]);
      end
    end
    plen = pat_q.size();
    nedges = nedges_in;
    if (nedges <= 0) begin
      if (hold) nedges = 4;
      else if (m == 2'd1) nedges = plen * d + 2;
      else nedges = 2 * plen * d + 3;
      if (nedges > 80) nedges = 80;
    end
    stray = 0;
    start_cfg(m, s, e, st, dw);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    exp_div = s;
    for (int k = 0; k < nedges; k++) begin
      if (poke && k == 2) begin
        @(negedge clk); cfg_start = 1'b1; scramble_cfg();
        @(negedge clk); cfg_start = 1'b0;
      end
      sync_edge();
      if (hold) begin
        exp_div = s; exp_stb = (k == 0); exp_done = 1'b0; exp_busy = 1'b1;
      end else if (m == 2'd1 && k >= plen * d) begin
        exp_div = e; exp_stb = 1'b0; exp_done = (k == plen * d); exp_busy = 1'b0;
      end else begin
        idx = (k / d) % plen;
        exp_div = pat_q[idx]; exp_stb = ((k % d) == 0); exp_done = 1'b0; exp_busy = 1'b1;
      end
      checks++;
      if (obs_div !== 16'(exp_div)) begin
        errors++; $display("FAIL %s nco_div edge %0d: got %0d want %0d", name, k, obs_div, exp_div);
      end
      checks++;
      if (obs_stb !== exp_stb) begin
        errors++; $display("FAIL %s step_stb edge %0d: got %b want %b", name, k, obs_stb, exp_stb);
      end
      checks++;
      if (obs_done !== exp_done) begin
        errors++; $display("FAIL %s done edge %0d: got %b want %b", name, k, obs_done, exp_done);
      end
      checks++;
      if (obs_busy !== exp_busy) begin
        errors++; $display("FAIL %s busy edge %0d: got %b want %b", name, k, obs_busy, exp_busy);
      end
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL %s stray_pulses: got %0d want 0", name, stray);
    end
    @(negedge clk); cfg_abort = 1'b1;
    @(negedge clk); cfg_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || nco_div !== 16'(exp_div)) begin
      errors++; $display("FAIL %s abort_close: got busy=%b div=%0d want busy=0 div=%0d", name, busy, nco_div, exp_div);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (nco_div !== 16'd8 || busy !== 1'b0 || step_stb !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_values: got div=%0d busy=%b stb=%b done=%b want 8 0 0 0", nco_div, busy, step_stb, done);
    end
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      sync_edge();
      checks++;
      if (obs_div !== 16'd8 || obs_stb !== 1'b0 || obs_busy !== 1'b0) begin
        errors++; $display("FAIL idle_sync %0d: got div=%0d stb=%b busy=%b want 8 0 0", i, obs_div, obs_stb, obs_busy);
      end
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL idle_stray: got %0d want 0", stray);
    end
  endtask

  task automatic test_oneshot();
    run_sweep("oneshot", 2'd1, 188, 376, 47, 2, 13, 1'b0);
  endtask

  task automatic test_clamp();
    run_sweep("clamp_up", 2'd1, 188, 376, 100, 1, 0, 1'b0);
    run_sweep("clamp_down", 2'd1, 376, 188, 100, 1, 0, 1'b0);
    run_sweep("clamp_top", 2'd1, 65500, 65535, 100, 1, 0, 1'b0);
    run_sweep("clamp_zero", 2'd1, 50, 0, 100, 1, 0, 1'b0);
  endtask

  task automatic test_modes();
    run_sweep("triangle", 2'd3, 10, 14, 2, 1, 12, 1'b0);
    run_sweep("repeat", 2'd2, 100, 130, 10, 2, 20, 1'b0);
    run_sweep("tri_down", 2'd3, 376, 188, 100, 2, 0, 1'b0);
  endtask

  task automatic test_edge_cases();
    run_sweep("dwell0", 2'd1, 10, 16, 3, 0, 5, 1'b0);
    run_sweep("step0", 2'd1, 100, 200, 0, 3, 5, 1'b0);
    run_sweep("hold", 2'd0, 55, 999, 7, 1, 4, 1'b0);
    run_sweep("same_bounds", 2'd3, 77, 77, 5, 1, 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep("busy_start1", 2'd1, 20, 60, 9, 1, 8, 1'b1);
    run_sweep("busy_start2", 2'd2, 300, 200, 33, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    int m, s, e, st, dw;
    for (int i = 0; i < 10; i++) begin
      m  = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      if (i % 2 == 1) begin
        s = $urandom_range(0, 65535); e = $urandom_range(0, 65535); st = $urandom_range(1, 40000);
      end else begin
        s = $urandom_range(0, 60); e = $urandom_range(0, 60); st = $urandom_range(1, 25);
      end
      run_sweep("random", 2'(m), s, e, st, dw, 0, bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_abort();
    start_cfg(2'd1, 188, 376, 47, 2);
    for (int k = 0; k < 6; k++) sync_edge();
    checks++;
    if (obs_div !== 16'd282) begin
      errors++; $display("FAIL abort_setup: got %0d want 282", obs_div);
    end
    @(negedge clk); nco_sync = 1'b1; cfg_abort = 1'b1;
    @(negedge clk); cfg_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || nco_div !== 16'd282 || step_stb !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_with_sync: got busy=%b div=%0d stb=%b done=%b want 0 282 0 0", busy, nco_div, step_stb, done);
    end
    @(negedge clk); nco_sync = 1'b0;
    @(negedge clk); cfg_start = 1'b1; cfg_abort = 1'b1;
    @(negedge clk); cfg_start = 1'b0; cfg_abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_beats_start: got busy=%b want 0", busy);
    end
    sync_edge();
    checks++;
    if (obs_div !== 16'd282 || obs_stb !== 1'b0 || obs_busy !== 1'b0) begin
      errors++; $display("FAIL after_abort_sync: got div=%0d stb=%b busy=%b want 282 0 0", obs_div, obs_stb, obs_busy);
    end
  endtask

  task automatic test_rst_mid();
    start_cfg(2'd1, 188, 376, 47, 1);
    sync_edge();
    sync_edge();
    checks++;
    if (obs_div !== 16'd235) begin
      errors++; $display("FAIL rst_setup: got %0d want 235", obs_div);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (nco_div !== 16'd8 || busy !== 1'b0 || step_stb !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got div=%0d busy=%b stb=%b done=%b want 8 0 0 0", nco_div, busy, step_stb, done);
    end
    rst = 1'b0;
    sync_edge();
    checks++;
    if (obs_div !== 16'd8 || obs_stb !== 1'b0 || obs_busy !== 1'b0) begin
      errors++; $display("FAIL rst_then_sync: got div=%0d stb=%b busy=%b want 8 0 0", obs_div, obs_stb, obs_busy);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_clamp();
    test_modes();
    test_edge_cases();
    test_back_to_back();
    test_random();
    test_abort();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
